// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) used for IF/ID bubbles
//   if_state_t       : fetch FSM state encoding
//   align_word()     : clears the two low address bits of a byte address
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } if_state_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with redirect mux and +4 incrementer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pc <= RESET_PC)
//   redirect   : load the word-aligned target; wins over advance
//   target     : redirect target address
//   advance    : step pc by 4 (wraps modulo 2^32)
//   pc         : current fetch address
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= align_word(target);
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, 1-entry hold buffer for
// responses that arrive while IF/ID is stalled, and the IF/ID register.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   stall                           : hazard unit holds IF/ID
//   branch_taken, pc_branch         : EX-stage redirect pulse and target
//   imem_req_valid/ready/addr       : fetch request handshake
//   imem_rsp_valid/data             : instruction response
//   ifid_valid/pc/pc_plus4/instr    : IF/ID pipeline register
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request pending on the bus at address pc
// WAIT  | request accepted, waiting for its response
// HOLD  | response captured in the hold buffer, waiting for stall to drop
// DROP  | a redirect orphaned the outstanding request; discard its response
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr
);

  if_state_t   state, state_nxt;
  logic        req_enable;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        req_fire;
  logic        deliver_rsp;
  logic        deliver_hold;
  logic        capture_hold;
  logic [31:0] src_pc;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .redirect (branch_taken),
    .target   (pc_branch),
    .advance  (req_fire),
    .pc       (pc)
  );

  // req_enable keeps the request low for the first cycle after reset release.
  assign imem_req_valid = req_enable && (state == ST_REQ);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_nxt    = state;
    deliver_rsp  = 1'b0;
    deliver_hold = 1'b0;
    capture_hold = 1'b0;
    case (state)
      ST_REQ:  if (req_fire) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (stall) begin
            capture_hold = 1'b1;
            state_nxt    = ST_HOLD;
          end else begin
            deliver_rsp  = 1'b1;
            state_nxt    = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          deliver_hold = hold_valid;
          state_nxt    = ST_REQ;
        end
      end
      ST_DROP: if (imem_rsp_valid) state_nxt = ST_REQ;
    endcase
    // A redirect overrides everything; if a request is still in flight (or
    // was just accepted) its response must be swallowed in DROP.
    if (branch_taken) begin
      deliver_rsp  = 1'b0;
      deliver_hold = 1'b0;
      capture_hold = 1'b0;
      if ((((state == ST_WAIT) || (state == ST_DROP)) && !imem_rsp_valid) || req_fire) begin
        state_nxt = ST_DROP;
      end else begin
        state_nxt = ST_REQ;
      end
    end
  end

  assign src_pc = deliver_hold ? hold_pc : fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REQ;
      req_enable <= 1'b0;
      fetch_pc   <= 32'd0;
    end else begin
      state      <= state_nxt;
      req_enable <= 1'b1;
      if (req_fire) fetch_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_pc    <= 32'd0;
      hold_instr <= NOP_INSTR;
    end else if (branch_taken) begin
      hold_valid <= 1'b0;
    end else if (capture_hold) begin
      hold_valid <= 1'b1;
      hold_pc    <= fetch_pc;
      hold_instr <= imem_rsp_data;
    end else if (deliver_hold) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid    <= 1'b0;
      ifid_pc       <= 32'd0;
      ifid_pc_plus4 <= 32'd0;
      ifid_instr    <= NOP_INSTR;
    end else if (branch_taken) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (deliver_rsp || deliver_hold) begin
      ifid_valid    <= 1'b1;
      ifid_pc       <= src_pc;
      ifid_pc_plus4 <= src_pc + 32'd4;
      ifid_instr    <= deliver_hold ? hold_instr : imem_rsp_data;
    end else if (!stall) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a transaction-level model (outstanding flag, discard
// flag, held-instruction queue) checked against the DUT every cycle, plus
// literal expectations at key points. A second instance with RESET_PC at
// the top of the address space shares the stimulus to cover wrap-around.
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] pc_branch = 32'd0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;

  logic        imem_req_valid, w_req_valid;
  logic [31:0] imem_req_addr, w_req_addr;
  logic        ifid_valid, w_ifid_valid;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
  logic [31:0] w_ifid_pc, w_ifid_pc_plus4, w_ifid_instr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .pc_branch(pc_branch), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_instr(ifid_instr)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .pc_branch(pc_branch), .imem_req_valid(w_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ifid_valid(w_ifid_valid), .ifid_pc(w_ifid_pc), .ifid_pc_plus4(w_ifid_pc_plus4),
    .ifid_instr(w_ifid_instr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_fetch_pc;
  logic        m_run, m_out, m_discard;
  logic        m_ifid_valid;
  logic [31:0] m_ifid_pc, m_ifid_pc4, m_ifid_instr;
  logic [31:0] h_pc[$];
  logic [31:0] h_instr[$];
  bit          m_fire, m_got;

  function automatic bit m_req_valid();
    return m_run && !m_out && (h_pc.size() == 0);
  endfunction

  task automatic m_deliver(input logic [31:0] p, input logic [31:0] ins);
    m_ifid_valid = 1'b1;
    m_ifid_pc    = p;
    m_ifid_pc4   = p + 32'd4;
    m_ifid_instr = ins;
  endtask

  task automatic m_bubble();
    m_ifid_valid = 1'b0;
    m_ifid_instr = NOP_INSTR;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'd0; m_fetch_pc = 32'd0;
      m_run = 1'b0; m_out = 1'b0; m_discard = 1'b0;
      m_ifid_valid = 1'b0; m_ifid_pc = 32'd0; m_ifid_pc4 = 32'd0; m_ifid_instr = NOP_INSTR;
      h_pc.delete(); h_instr.delete();
    end else begin
      m_fire = m_req_valid() && imem_req_ready;
      m_got  = m_out && imem_rsp_valid;
      if (branch_taken) begin
        m_bubble();
        h_pc.delete(); h_instr.delete();
        m_discard = (m_out && !imem_rsp_valid) || m_fire;
        m_out     = m_discard;
        m_pc      = pc_branch & 32'hFFFF_FFFC;
      end else begin
        if (m_got) begin
          m_out = 1'b0;
          if (m_discard) begin
            m_discard = 1'b0;
            if (!stall) m_bubble();
          end else if (stall) begin
            h_pc.push_back(m_fetch_pc);
            h_instr.push_back(imem_rsp_data);
          end else begin
            m_deliver(m_fetch_pc, imem_rsp_data);
          end
        end else if (h_pc.size() > 0 && !stall) begin
          m_deliver(h_pc.pop_front(), h_instr.pop_front());
        end else if (!stall) begin
          m_bubble();
        end
        if (m_fire) begin
          m_fetch_pc = m_pc;
          m_pc       = m_pc + 32'd4;
          m_out      = 1'b1;
        end
      end
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("req_valid",  32'(imem_req_valid), 32'(m_req_valid()));
    check("req_addr",   imem_req_addr, m_pc);
    check("ifid_valid", 32'(ifid_valid), 32'(m_ifid_valid));
    check("ifid_pc",    ifid_pc, m_ifid_pc);
    check("ifid_pc4",   ifid_pc_plus4, m_ifid_pc4);
    check("ifid_instr", ifid_instr, m_ifid_instr);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] d,
                     input logic st, input logic br, input logic [31:0] tgt);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = d;
    stall          = st;
    branch_taken   = br;
    pc_branch      = tgt;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_req_valid",  32'(imem_req_valid), 32'd0);
    check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    check("rst_ifid_instr", ifid_instr, 32'h0000_0013);
    check("rst_wrap_addr",  w_req_addr, 32'hFFFF_FFFC);

    // reset release and back-to-back fetches
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr",  imem_req_addr, 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0010_0093, 0, 0, 0);
    check("f0_valid", 32'(ifid_valid), 32'd1);
    check("f0_pc",    ifid_pc, 32'h0);
    check("f0_pc4",   ifid_pc_plus4, 32'h4);
    check("f0_instr", ifid_instr, 32'h0010_0093);
    check("f1_addr",  imem_req_addr, 32'h4);
    check("wrap_pc",    w_ifid_pc, 32'hFFFF_FFFC);
    check("wrap_pc4",   w_ifid_pc_plus4, 32'h0);
    check("wrap_instr", w_ifid_instr, 32'h0010_0093);
    check("wrap_addr2", w_req_addr, 32'h0);
    check("wrap_valid", 32'(w_req_valid), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("bubble_valid", 32'(ifid_valid), 32'd0);
    check("bubble_instr", ifid_instr, 32'h0000_0013);
    check("wrap_bubble",  32'(w_ifid_valid), 32'd0);
    cyc(0, 1, 32'h0020_0113, 0, 0, 0);
    check("f2_addr", imem_req_addr, 32'h8);

    // stalled response goes to the hold buffer
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0030_0193, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("hold_no_req", 32'(imem_req_valid), 32'd0);
    check("hold_ifid",   ifid_instr, 32'h0020_0113);
    cyc(1, 0, 0, 1, 0, 0);
    check("hold_ifid_pc", ifid_pc, 32'h4);
    cyc(1, 0, 0, 0, 0, 0);
    check("held_out_pc",    ifid_pc, 32'h8);
    check("held_out_instr", ifid_instr, 32'h0030_0193);
    check("after_hold_addr", imem_req_addr, 32'hC);
    cyc(1, 0, 0, 0, 0, 0);
    check("no_dup", 32'(ifid_valid), 32'd0);

    // redirect while waiting: late response dropped
    cyc(0, 0, 0, 0, 1, 32'h100);
    check("redir_ifid_valid", 32'(ifid_valid), 32'd0);
    check("redir_addr",       imem_req_addr, 32'h100);
    check("drop_no_req",      32'(imem_req_valid), 32'd0);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("late_dropped", 32'(ifid_valid), 32'd0);
    check("redir_req",    32'(imem_req_valid), 32'd1);

    // redirect and response together under stall
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0040_0213, 0, 0, 0);
    check("f100_pc", ifid_pc, 32'h100);
    cyc(1, 0, 0, 1, 0, 0);
    check("stall_keep", 32'(ifid_valid), 32'd1);
    cyc(0, 1, 32'hBAD0_0001, 1, 1, 32'h100);
    check("flush_valid", 32'(ifid_valid), 32'd0);
    check("flush_instr", ifid_instr, 32'h0000_0013);
    check("flush_addr",  imem_req_addr, 32'h100);
    check("flush_req",   32'(imem_req_valid), 32'd1);

    // redirect in the cycle a request is accepted, misaligned target
    cyc(1, 0, 0, 0, 1, 32'h0000_0203);
    check("hs_redir_req",  32'(imem_req_valid), 32'd0);
    check("hs_redir_addr", imem_req_addr, 32'h200);
    cyc(0, 1, 32'hBAD0_0002, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0050_0293, 0, 0, 0);
    check("f200_pc4", ifid_pc_plus4, 32'h204);

    // redirect while holding clears the buffer
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0060_0313, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h300);
    check("hold_redir_addr", imem_req_addr, 32'h300);
    cyc(1, 0, 0, 0, 0, 0);
    check("hold_cleared", 32'(ifid_valid), 32'd0);

    // reset while waiting, stray responses afterwards
    rst_n = 1'b0;
    #1;
    check("arst_req_valid",  32'(imem_req_valid), 32'd0);
    check("arst_addr",       imem_req_addr, 32'h0);
    check("arst_ifid_valid", 32'(ifid_valid), 32'd0);
    check("arst_ifid_pc",    ifid_pc, 32'h0);
    check("arst_ifid_instr", ifid_instr, 32'h0000_0013);
    @(posedge clk);
    #2;
    cyc(0, 1, 32'hBAD0_0003, 0, 0, 0);
    rst_n = 1'b1;
    cyc(1, 1, 32'hBAD0_0004, 0, 0, 0);
    check("stray_ignored", 32'(ifid_valid), 32'd0);
    cyc(1, 1, 32'hBAD0_0005, 0, 0, 0);
    check("stray_ignored2", 32'(ifid_valid), 32'd0);
    cyc(0, 1, 32'h0070_0393, 0, 0, 0);
    check("post_rst_pc",    ifid_pc, 32'h0);
    check("post_rst_instr", ifid_instr, 32'h0070_0393);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
